// File: rtl/cgia_bus_arbiter.sv
// Two-master shared-bus arbiter: video fetcher and CPU share one memory port.
// Video wins ties; a waiting CPU is forced in after BURST_MAX video words.
module cgia_bus_arbiter #(
    parameter int unsigned ADR_W     = 23,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             v_cyc_i,
    input  logic [ADR_W-1:0] v_adr_i,
    output logic             v_ack_o,
    input  logic             c_cyc_i,
    input  logic             c_stb_i,
    input  logic             c_we_i,
    input  logic [ADR_W-1:0] c_adr_i,
    input  logic [15:0]      c_dat_i,
    input  logic [1:0]       c_sel_i,
    output logic             c_ack_o,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    output logic [ADR_W-1:0] m_adr_o,
    output logic [15:0]      m_dat_o,
    output logic [1:0]       m_sel_o,
    input  logic             m_ack_i,
    output logic [1:0]       grant_o
);

    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_VID  = 2'b01;
    localparam logic [1:0] ST_CPU  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    logic [1:0]       state_q,     state_d;
    logic             cpu_prio_q,  cpu_prio_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            cpu_prio_q  <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_prio_q  <= cpu_prio_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state logic; every ownership change passes through IDLE
    always_comb begin
        state_d     = state_q;
        cpu_prio_d  = cpu_prio_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_prio_q && c_cyc_i) begin
                    state_d = ST_CPU;
                end else if (v_cyc_i) begin
                    state_d = ST_VID;
                end else if (c_cyc_i) begin
                    state_d = ST_CPU;
                end
            end
            ST_VID: begin
                if (v_cyc_i && m_ack_i && c_cyc_i && (burst_cnt_q != CNT_MAX)) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                if (!v_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (m_ack_i && c_cyc_i && (burst_cnt_q == CNT_LAST)) begin
                    // Preempt between words; the fetcher stalls with cyc still high
                    state_d    = ST_IDLE;
                    cpu_prio_d = 1'b1;
                end
            end
            ST_CPU: begin
                if (!c_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_CPU) && (state_q != ST_CPU)) begin
            cpu_prio_d  = 1'b0;
            burst_cnt_d = '0;
        end
    end

    // Bus mux; acks are gated by the owner's cyc and suppressed while in reset
    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_adr_o = '0;
        m_dat_o = '0;
        m_sel_o = '0;
        v_ack_o = 1'b0;
        c_ack_o = 1'b0;
        case (state_q)
            ST_VID: begin
                m_cyc_o = v_cyc_i;
                m_stb_o = v_cyc_i;
                m_sel_o = 2'b11;
                m_adr_o = v_adr_i;
                v_ack_o = m_ack_i & v_cyc_i & reset_ni;
            end
            ST_CPU: begin
                m_cyc_o = c_cyc_i;
                m_stb_o = c_cyc_i & c_stb_i;
                m_we_o  = c_we_i;
                m_adr_o = c_adr_i;
                m_dat_o = c_dat_i;
                m_sel_o = c_sel_i;
                c_ack_o = m_ack_i & c_cyc_i & reset_ni;
            end
            default: ;
        endcase
    end

    assign grant_o = state_q;

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// Scoreboard bench for cgia_bus_arbiter: directed cycles push expected acks,
// a negedge monitor pops and checks each forwarded ack.
module tb_cgia_bus_arbiter;

    localparam int unsigned AW = 23;

    typedef struct packed {
        logic [1:0]    kind;   // 01 video ack, 10 cpu ack
        logic [AW-1:0] adr;
        logic          we;
        logic [15:0]   dat;
        logic [1:0]    sel;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          v_cyc_i;
    logic [AW-1:0] v_adr_i;
    logic          v_ack_o;
    logic          c_cyc_i, c_stb_i, c_we_i;
    logic [AW-1:0] c_adr_i;
    logic [15:0]   c_dat_i;
    logic [1:0]    c_sel_i;
    logic          c_ack_o;
    logic          m_cyc_o, m_stb_o, m_we_o;
    logic [AW-1:0] m_adr_o;
    logic [15:0]   m_dat_o;
    logic [1:0]    m_sel_o;
    logic          m_ack_i;
    logic [1:0]    grant_o;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    cgia_bus_arbiter #(.ADR_W(AW), .BURST_MAX(4)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .v_cyc_i(v_cyc_i), .v_adr_i(v_adr_i), .v_ack_o(v_ack_o),
        .c_cyc_i(c_cyc_i), .c_stb_i(c_stb_i), .c_we_i(c_we_i),
        .c_adr_i(c_adr_i), .c_dat_i(c_dat_i), .c_sel_i(c_sel_i), .c_ack_o(c_ack_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_ack_i(m_ack_i), .grant_o(grant_o)
    );

    // Monitor: every forwarded ack must match the oldest expectation
    always @(negedge clk) begin
        if (mon_en && (v_ack_o || c_ack_o)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack t=%0t got v_ack=%b c_ack=%b adr=%h, required no ack",
                         $time, v_ack_o, c_ack_o, m_adr_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({c_ack_o, v_ack_o} !== e.kind || m_adr_o !== e.adr || m_we_o !== e.we ||
                    m_dat_o !== e.dat || m_sel_o !== e.sel) begin
                    n_err++;
                    $display("FAIL ack_payload t=%0t got ack=%b adr=%h we=%b dat=%h sel=%b, required ack=%b adr=%h we=%b dat=%h sel=%b",
                             $time, {c_ack_o, v_ack_o}, m_adr_o, m_we_o, m_dat_o, m_sel_o,
                             e.kind, e.adr, e.we, e.dat, e.sel);
                end
            end
        end
    end

    task automatic expect_ack(input logic [1:0] kind, input logic [AW-1:0] adr,
                              input logic we, input logic [15:0] dat, input logic [1:0] sel);
        exp_t e;
        e.kind = kind; e.adr = adr; e.we = we; e.dat = dat; e.sel = sel;
        exp_q.push_back(e);
    endtask

    // Check owner and bus cycle for the current cycle, then advance one clock
    task automatic tick(input logic [1:0] eg, input logic ecyc);
        @(negedge clk);
        n_cmp++;
        if (grant_o !== eg) begin
            n_err++;
            $display("FAIL grant t=%0t got %b required %b", $time, grant_o, eg);
        end
        n_cmp++;
        if (m_cyc_o !== ecyc) begin
            n_err++;
            $display("FAIL m_cyc t=%0t got %b required %b", $time, m_cyc_o, ecyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic cyc, input logic we, input logic [AW-1:0] adr,
                             input logic [15:0] dat, input logic [1:0] sel);
        c_cyc_i = cyc; c_stb_i = cyc; c_we_i = we;
        c_adr_i = adr; c_dat_i = dat; c_sel_i = sel;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got no finish, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every request and the slave ack asserted
        reset_ni = 1'b0; m_ack_i = 1'b1;
        v_cyc_i = 1'b1; v_adr_i = '0;
        cpu_drive(1'b1, 1'b1, '0, 16'h0, 2'b11);
        @(posedge clk); #1;
        mon_en = 1'b1;
        tick(2'b00, 1'b0);
        tick(2'b00, 1'b0);
        reset_ni = 1'b1; m_ack_i = 1'b0; v_cyc_i = 1'b0;
        cpu_drive(1'b0, 1'b0, '0, 16'h0, 2'b00);
        tick(2'b00, 1'b0);

        // Video-only 5-word burst, ack every cycle
        v_cyc_i = 1'b1; v_adr_i = AW'(32'h000040); m_ack_i = 1'b1;
        tick(2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            v_adr_i = AW'(32'h000040 + i);
            expect_ack(2'b01, AW'(32'h000040 + i), 1'b0, 16'h0000, 2'b11);
            tick(2'b01, 1'b1);
        end
        v_cyc_i = 1'b0;
        tick(2'b01, 1'b0);
        m_ack_i = 1'b0;
        tick(2'b00, 1'b0);

        // CPU-only single write
        cpu_drive(1'b1, 1'b1, AW'(32'h000123), 16'hBEEF, 2'b01);
        tick(2'b00, 1'b0);
        tick(2'b10, 1'b1);
        m_ack_i = 1'b1;
        expect_ack(2'b10, AW'(32'h000123), 1'b1, 16'hBEEF, 2'b01);
        tick(2'b10, 1'b1);
        m_ack_i = 1'b0;
        cpu_drive(1'b0, 1'b0, '0, 16'h0, 2'b00);
        tick(2'b10, 1'b0);
        tick(2'b00, 1'b0);

        // Preemption: CPU waits through exactly 4 video words
        v_cyc_i = 1'b1; v_adr_i = AW'(32'h000100); m_ack_i = 1'b1;
        tick(2'b00, 1'b0);
        expect_ack(2'b01, AW'(32'h000100), 1'b0, 16'h0, 2'b11);
        tick(2'b01, 1'b1);
        cpu_drive(1'b1, 1'b0, AW'(32'h000200), 16'h0000, 2'b11);
        for (int i = 1; i <= 4; i++) begin
            v_adr_i = AW'(32'h000100 + i);
            expect_ack(2'b01, AW'(32'h000100 + i), 1'b0, 16'h0, 2'b11);
            tick(2'b01, 1'b1);
        end
        v_adr_i = AW'(32'h000105);
        tick(2'b00, 1'b0);
        expect_ack(2'b10, AW'(32'h000200), 1'b0, 16'h0000, 2'b11);
        tick(2'b10, 1'b1);
        cpu_drive(1'b0, 1'b0, '0, 16'h0, 2'b00);
        tick(2'b10, 1'b0);
        tick(2'b00, 1'b0);
        expect_ack(2'b01, AW'(32'h000105), 1'b0, 16'h0, 2'b11);
        tick(2'b01, 1'b1);
        v_adr_i = AW'(32'h000106);
        expect_ack(2'b01, AW'(32'h000106), 1'b0, 16'h0, 2'b11);
        tick(2'b01, 1'b1);
        v_cyc_i = 1'b0; m_ack_i = 1'b0;
        tick(2'b01, 1'b0);
        tick(2'b00, 1'b0);

        // Simultaneous request with no priority: video first, CPU after
        v_cyc_i = 1'b1; v_adr_i = AW'(32'h000300);
        cpu_drive(1'b1, 1'b1, AW'(32'h000400), 16'h1234, 2'b10);
        tick(2'b00, 1'b0);
        m_ack_i = 1'b1;
        expect_ack(2'b01, AW'(32'h000300), 1'b0, 16'h0, 2'b11);
        tick(2'b01, 1'b1);
        v_cyc_i = 1'b0; m_ack_i = 1'b0;
        tick(2'b01, 1'b0);
        tick(2'b00, 1'b0);
        m_ack_i = 1'b1;
        expect_ack(2'b10, AW'(32'h000400), 1'b1, 16'h1234, 2'b10);
        tick(2'b10, 1'b1);
        m_ack_i = 1'b0;
        cpu_drive(1'b0, 1'b0, '0, 16'h0, 2'b00);
        tick(2'b10, 1'b0);
        tick(2'b00, 1'b0);

        // Reset in the middle of a CPU cycle with the slave acking
        cpu_drive(1'b1, 1'b0, AW'(32'h000055), 16'h0, 2'b11);
        tick(2'b00, 1'b0);
        tick(2'b10, 1'b1);
        reset_ni = 1'b0; m_ack_i = 1'b1;
        tick(2'b10, 1'b1);
        reset_ni = 1'b1;
        cpu_drive(1'b0, 1'b0, '0, 16'h0, 2'b00);
        tick(2'b00, 1'b0);
        m_ack_i = 1'b0;
        tick(2'b00, 1'b0);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_acks got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cgia_bus_arbiter.md
CGIA_BUS_ARBITER -- requirements
Module: cgia_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADR_W, default 23, meaning word-address width (bits [ADR_W:1]).
REQ-002 The block SHALL have parameter BURST_MAX, default 8, meaning the number of video acks allowed while the CPU waits before the CPU is forced in.
REQ-003 The block SHALL have port clk_i, input, 1 bit: system clock; the block has one clock only, clk_i.
REQ-004 The block SHALL have port reset_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port v_cyc_i, input, 1 bit: video fetcher bus-cycle request.
REQ-006 The block SHALL have port v_adr_i, input, ADR_W bits: video fetcher word address.
REQ-007 The block SHALL have port v_ack_o, output, 1 bit: video fetcher word acknowledge.
REQ-008 The block SHALL have port c_cyc_i / c_stb_i / c_we_i, input, 1 bit each: CPU cycle, strobe and write enable.
REQ-009 The block SHALL have port c_adr_i, input, ADR_W bits: CPU word address.
REQ-010 The block SHALL have port c_dat_i, input, 16 bits: CPU write data.
REQ-011 The block SHALL have port c_sel_i, input, 2 bits: CPU byte selects.
REQ-012 The block SHALL have port c_ack_o, output, 1 bit: CPU acknowledge.
REQ-013 The block SHALL have port m_cyc_o / m_stb_o / m_we_o, output, 1 bit each: shared-bus cycle, strobe and write enable.
REQ-014 The block SHALL have port m_adr_o, output, ADR_W bits: shared-bus address.
REQ-015 The block SHALL have port m_dat_o, output, 16 bits: shared-bus write data.
REQ-016 The block SHALL have port m_sel_o, output, 2 bits: shared-bus byte selects.
REQ-017 The block SHALL have port m_ack_i, input, 1 bit: shared-bus acknowledge.
REQ-018 The block SHALL have port grant_o, output, 2 bits: current owner; 00 = none, 01 = video, 10 = CPU.

Function
REQ-019 The block SHALL implement a registered state machine with states IDLE, VID and CPU; grant_o SHALL encode the state.
REQ-020 In IDLE, m_cyc_o, m_stb_o and m_we_o SHALL be 0, both acks SHALL be 0, and m_ack_i SHALL be ignored.
REQ-021 In IDLE, the next state SHALL be chosen in this priority order:
- cpu_prio=1 and c_cyc_i=1 -> CPU;
- otherwise v_cyc_i=1 -> VID;
- otherwise c_cyc_i=1 -> CPU;
- otherwise stay in IDLE.
REQ-022 The latency from a request seen in IDLE at edge n to the granted master appearing on m_* SHALL be exactly one cycle (cycle n+1).
REQ-023 In VID, the bus outputs SHALL be driven combinationally as follows:
- m_cyc_o = m_stb_o = v_cyc_i;
- m_we_o = 0; m_sel_o = 2'b11; m_adr_o = v_adr_i; m_dat_o = 0;
- v_ack_o = m_ack_i & v_cyc_i; c_ack_o = 0.
REQ-024 In CPU, the bus outputs SHALL be driven combinationally as follows:
- m_cyc_o = c_cyc_i; m_stb_o = c_cyc_i & c_stb_i;
- m_we_o, m_adr_o, m_dat_o and m_sel_o = the corresponding c_* inputs;
- c_ack_o = m_ack_i & c_cyc_i; v_ack_o = 0.
REQ-025 burst_cnt (width clog2(BURST_MAX+1)) SHALL increment on each VID-state ack while c_cyc_i=1, SHALL saturate at BURST_MAX, and SHALL clear on entry to CPU.
REQ-026 In VID, when m_ack_i=1, c_cyc_i=1 and burst_cnt=BURST_MAX-1, the next state SHALL be IDLE and cpu_prio SHALL be set to 1 (preemption between words; v_cyc_i stays high and the fetcher simply stalls).
REQ-027 In VID, when v_cyc_i=0, the next state SHALL be IDLE.
REQ-028 In CPU, when c_cyc_i=0, the next state SHALL be IDLE; cpu_prio SHALL clear on entry to CPU.
REQ-029 Every ownership change SHALL pass through IDLE, so m_cyc_o is low for at least one cycle between owners; there SHALL be no direct VID<->CPU transition.
REQ-030 The CPU SHALL hold the bus for as long as c_cyc_i stays high, with no timeout; line-buffer underrun caused by long CPU cycles is a software constraint.
REQ-031 When v_cyc_i and c_cyc_i rise in the same cycle in IDLE with cpu_prio=0, video SHALL win.
REQ-032 An ack that coincides with the requester dropping cyc SHALL NOT be forwarded (acks are gated by the requester's cyc).
REQ-033 If cpu_prio=1 but c_cyc_i has dropped while in IDLE, video SHALL be granted normally and cpu_prio SHALL remain set until the next CPU entry.

Reset
REQ-034 When reset_ni=0 at a clock edge, the following SHALL hold from the next cycle, regardless of state or outstanding cycles:
- state = IDLE, cpu_prio = 0, burst_cnt = 0;
- m_cyc_o, m_stb_o, m_we_o, v_ack_o and c_ack_o = 0; grant_o = 00.
REQ-035 An ack arriving during or right after reset SHALL NOT be forwarded.

Verification
REQ-036 Video-only: v_cyc_i high for a 5-word burst with an ack every cycle -> grant_o=01 one cycle after request, 5 v_ack_o pulses, m_adr_o tracks v_adr_i, then IDLE.
REQ-037 CPU-only: single write, adr=0x000123, dat=0xBEEF, sel=01 -> m_we_o=1, m_adr_o=0x000123, m_dat_o=0xBEEF, one c_ack_o, grant_o returns to 00 when c_cyc_i drops.
REQ-038 Preemption (BURST_MAX=4): CPU requests during a long video burst -> exactly 4 v_ack_o, one IDLE cycle, CPU granted, and video resumes after c_cyc_i drops with no v_ack_o lost or duplicated.
REQ-039 Simultaneous request in IDLE with cpu_prio=0 -> VID granted; the CPU waits until v_cyc_i=0 or preemption occurs.
REQ-040 Reset mid-CPU-cycle (reset_ni=0 with m_ack_i=1) -> c_ack_o=0, m_cyc_o=0 and grant_o=00 on the next cycle.
